// File: rtl/qspi_multi_counter.sv
// ---------------------------------------------------------------------------
// qspi_multi_counter
// Bank of NUM_CH independent clock-cycle counters used by the Quad SPI
// controller for SCK division, dummy cycles, byte/bit counting and CS timing.
// Each channel has a programmable step, limit and preload. A per-channel mode
// selects saturate-at-limit or wrap-to-zero, and a channel emits a one-cycle
// terminal-count pulse when an enabled step lands on the limit.
//
// Ports (channel c of a packed bus lives at [c*WIDTH +: WIDTH]):
//   clk_i        clock, rising edge
//   rst_ni       synchronous active-low reset
//   enable_i     per-channel count enable
//   clear_i      per-channel synchronous clear (highest priority)
//   load_i       per-channel preload strobe (unclamped)
//   load_val_i   packed preload values
//   max_count_i  packed per-channel limits
//   incr_val_i   packed per-channel step sizes
//   wrap_i       per-channel mode: 0 = saturate, 1 = wrap to 0 after limit
//   count_o      packed registered counts
//   at_max_o     combinational count == limit
//   tc_pulse_o   registered one-cycle terminal-count pulse
// ---------------------------------------------------------------------------
module qspi_multi_counter #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_CH-1:0]         enable_i,
    input  logic [NUM_CH-1:0]         clear_i,
    input  logic [NUM_CH-1:0]         load_i,
    input  logic [NUM_CH*WIDTH-1:0]   load_val_i,
    input  logic [NUM_CH*WIDTH-1:0]   max_count_i,
    input  logic [NUM_CH*WIDTH-1:0]   incr_val_i,
    input  logic [NUM_CH-1:0]         wrap_i,
    output logic [NUM_CH*WIDTH-1:0]   count_o,
    output logic [NUM_CH-1:0]         at_max_o,
    output logic [NUM_CH-1:0]         tc_pulse_o
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [WIDTH-1:0] max_s;
        logic [WIDTH-1:0] incr_s;
        logic [WIDTH-1:0] load_s;
        logic [WIDTH:0]   sum_s;
        logic             over_s;
        logic             reach_s;
        logic [WIDTH-1:0] count_d;
        logic [WIDTH-1:0] count_q;
        logic             tc_d;
        logic             tc_q;

        assign max_s  = max_count_i[c*WIDTH +: WIDTH];
        assign incr_s = incr_val_i[c*WIDTH +: WIDTH];
        assign load_s = load_val_i[c*WIDTH +: WIDTH];

        // Sum carries one extra bit so a large step can never alias past the limit.
        assign sum_s   = {1'b0, count_q} + {1'b0, incr_s};
        assign over_s  = (count_q >= max_s);
        assign reach_s = (sum_s >= {1'b0, max_s});

        // Next-state selection: clear > load > enable > hold.
        always_comb begin
            count_d = count_q;
            tc_d    = 1'b0;
            if (clear_i[c]) begin
                count_d = {WIDTH{1'b0}};
            end else if (load_i[c]) begin
                count_d = load_s;
            end else if (enable_i[c]) begin
                if (over_s) begin
                    // Already at/above limit: saturate pulls down to max,
                    // wrap restarts; a zero limit in wrap mode re-fires tc.
                    if (wrap_i[c]) begin
                        count_d = {WIDTH{1'b0}};
                        tc_d    = (max_s == {WIDTH{1'b0}});
                    end else begin
                        count_d = max_s;
                    end
                end else if (reach_s) begin
                    count_d = max_s;
                    tc_d    = 1'b1;
                end else begin
                    count_d = sum_s[WIDTH-1:0];
                end
            end else begin
                count_d = count_q;
            end
        end

        // Count and terminal-count registers with synchronous reset.
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                count_q <= {WIDTH{1'b0}};
                tc_q    <= 1'b0;
            end else begin
                count_q <= count_d;
                tc_q    <= tc_d;
            end
        end

        assign count_o[c*WIDTH +: WIDTH] = count_q;
        assign at_max_o[c]               = (count_q == max_s);
        assign tc_pulse_o[c]             = tc_q;
    end

endmodule
